// File: rtl/alg_pkg.sv
// Shared types and default sizing for the alg_core streaming front-end.
package alg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    localparam int unsigned DEF_DATA_WIDTH  = 11;
    localparam int unsigned DEF_CTR_WIDTH   = 22;
    localparam int unsigned DEF_DATA_OFFSET = 1024;
    localparam int unsigned DEF_FIFO_DEPTH  = 16;
    localparam int unsigned DEF_SAMPLE_DIV  = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; push on full and pop on empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alg_stream_ctrl.sv
// Paces buffered offset-binary ECG samples into alg_core as signed values and
// holds alg_core RR-period events for a downstream consumer.
module alg_stream_ctrl
    import alg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned CTR_WIDTH   = DEF_CTR_WIDTH,
    parameter int unsigned DATA_OFFSET = DEF_DATA_OFFSET,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned SAMPLE_DIV  = DEF_SAMPLE_DIV
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  core_ce,
    output logic                  core_data_valid,
    output logic [DATA_WIDTH-1:0] core_ecg_value,
    input  logic [DATA_WIDTH-1:0] core_rr_period,
    input  logic                  core_rr_period_updated,
    input  logic [CTR_WIDTH-1:0]  core_r_peak_sample_num,
    output logic                  evt_valid,
    output logic [DATA_WIDTH-1:0] evt_rr_period,
    output logic [CTR_WIDTH-1:0]  evt_sample_num,
    input  logic                  evt_ready,
    output logic                  busy,
    output logic [CTR_WIDTH-1:0]  sample_count,
    output logic                  underrun,
    output logic                  evt_overflow
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    ctrl_state_t           state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic                  dv_q, dv_d;
    logic [DATA_WIDTH-1:0] ecg_q, ecg_d;
    logic [CTR_WIDTH-1:0]  scnt_q, scnt_d;
    logic                  urun_q, urun_d;
    logic                  ev_valid_q, ev_valid_d;
    logic [DATA_WIDTH-1:0] ev_rr_q, ev_rr_d;
    logic [CTR_WIDTH-1:0]  ev_idx_q, ev_idx_d;
    logic                  ev_ovf_q, ev_ovf_d;

    logic                  tick;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (in_valid),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready        = ~fifo_full;
    assign busy            = (state_q != IDLE);
    assign core_ce         = (state_q != IDLE);
    assign core_data_valid = dv_q;
    assign core_ecg_value  = ecg_q;
    assign sample_count    = scnt_q;
    assign underrun        = urun_q;
    assign evt_valid       = ev_valid_q;
    assign evt_rr_period   = ev_rr_q;
    assign evt_sample_num  = ev_idx_q;
    assign evt_overflow    = ev_ovf_q;

    assign tick = (state_q != IDLE) && (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        dv_d       = 1'b0;
        ecg_d      = ecg_q;
        scnt_d     = scnt_q;
        urun_d     = urun_q;
        ev_valid_d = ev_valid_q;
        ev_rr_d    = ev_rr_q;
        ev_idx_d   = ev_idx_q;
        ev_ovf_d   = ev_ovf_q;
        fifo_pop   = 1'b0;

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                if (start && !stop) begin
                    state_d  = RUN;
                    scnt_d   = '0;
                    urun_d   = 1'b0;
                    ev_ovf_d = 1'b0;
                end
            end
            RUN: begin
                if (stop) state_d = DRAIN;
                if (tick && fifo_empty) urun_d = 1'b1;
            end
            DRAIN: begin
                if (tick && fifo_empty) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        end

        // Issue: pop, convert offset-binary to two's complement, strobe once.
        if (tick && !fifo_empty) begin
            fifo_pop = 1'b1;
            dv_d     = 1'b1;
            ecg_d    = fifo_rdata - DATA_WIDTH'(DATA_OFFSET);
            if (scnt_q != '1) scnt_d = scnt_q + CTR_WIDTH'(1);
        end

        // Capture only while running; consumption is allowed in any state.
        if ((state_q != IDLE) && core_rr_period_updated) begin
            if (!ev_valid_q || evt_ready) begin
                ev_valid_d = 1'b1;
                ev_rr_d    = core_rr_period;
                ev_idx_d   = core_r_peak_sample_num;
            end else begin
                ev_ovf_d = 1'b1;
            end
        end else if (ev_valid_q && evt_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            dv_q       <= 1'b0;
            ecg_q      <= '0;
            scnt_q     <= '0;
            urun_q     <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_rr_q    <= '0;
            ev_idx_q   <= '0;
            ev_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            dv_q       <= dv_d;
            ecg_q      <= ecg_d;
            scnt_q     <= scnt_d;
            urun_q     <= urun_d;
            ev_valid_q <= ev_valid_d;
            ev_rr_q    <= ev_rr_d;
            ev_idx_q   <= ev_idx_d;
            ev_ovf_q   <= ev_ovf_d;
        end
    end

endmodule

// File: tb/tb_alg_stream_ctrl.sv
// Directed bench for alg_stream_ctrl with hand-computed expectations.
module tb_alg_stream_ctrl;

    localparam int unsigned DW = 11;
    localparam int unsigned CW = 22;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start;
    logic          stop;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          core_ce;
    logic          core_data_valid;
    logic [DW-1:0] core_ecg_value;
    logic [DW-1:0] core_rr_period;
    logic          core_rr_period_updated;
    logic [CW-1:0] core_r_peak_sample_num;
    logic          evt_valid;
    logic [DW-1:0] evt_rr_period;
    logic [CW-1:0] evt_sample_num;
    logic          evt_ready;
    logic          busy;
    logic [CW-1:0] sample_count;
    logic          underrun;
    logic          evt_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    alg_stream_ctrl #(
        .DATA_WIDTH  (11),
        .CTR_WIDTH   (22),
        .DATA_OFFSET (1024),
        .FIFO_DEPTH  (16),
        .SAMPLE_DIV  (4)
    ) dut (
        .clk                    (clk),
        .nrst                   (nrst),
        .start                  (start),
        .stop                   (stop),
        .in_data                (in_data),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .core_ce                (core_ce),
        .core_data_valid        (core_data_valid),
        .core_ecg_value         (core_ecg_value),
        .core_rr_period         (core_rr_period),
        .core_rr_period_updated (core_rr_period_updated),
        .core_r_peak_sample_num (core_r_peak_sample_num),
        .evt_valid              (evt_valid),
        .evt_rr_period          (evt_rr_period),
        .evt_sample_num         (evt_sample_num),
        .evt_ready              (evt_ready),
        .busy                   (busy),
        .sample_count           (sample_count),
        .underrun               (underrun),
        .evt_overflow           (evt_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge; inputs set afterwards apply to the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic core_event(input logic [DW-1:0] rr, input logic [CW-1:0] idx, input logic rdy);
        core_rr_period         = rr;
        core_r_peak_sample_num = idx;
        core_rr_period_updated = 1'b1;
        evt_ready              = rdy;
        step();
        core_rr_period_updated = 1'b0;
        evt_ready              = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            step();
            n++;
        end
        check_eq("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; start = 1'b0; stop = 1'b0;
        in_data = '0; in_valid = 1'b0;
        core_rr_period = '0; core_rr_period_updated = 1'b0;
        core_r_peak_sample_num = '0; evt_ready = 1'b0;
        step(); step();
        nrst = 1'b1;

        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ce", 32'(core_ce), 32'd0);
        check_eq("rst_dv", 32'(core_data_valid), 32'd0);
        check_eq("rst_evt_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_scnt", 32'(sample_count), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);

        // Prefill three samples, start, and track strobes over E+1..E+12.
        push(11'd1024); push(11'd1500); push(11'd200);
        pulse_start();
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) check_eq("ce_after_start", 32'(core_ce), 32'd1);
            check_eq($sformatf("strobe_k%0d", k), 32'(core_data_valid),
                     32'((k % 4) == 0));
            if (k == 4)  check_eq("val0", 32'(core_ecg_value), 32'd0);
            if (k == 8)  check_eq("val1", 32'(core_ecg_value), 32'd476);
            if (k == 12) check_eq("val2", 32'(core_ecg_value), 32'h4C8);
        end
        check_eq("scnt3", 32'(sample_count), 32'd3);
        check_eq("no_underrun_yet", 32'(underrun), 32'd0);

        // Stop with empty FIFO: drain ends at E+16 without flagging underrun.
        pulse_stop();
        step(); step();
        check_eq("drain_busy", 32'(busy), 32'd1);
        step();
        check_eq("drain_done_busy", 32'(busy), 32'd0);
        check_eq("drain_done_ce", 32'(core_ce), 32'd0);
        check_eq("drain_no_underrun", 32'(underrun), 32'd0);

        // Empty FIFO at first tick in RUN.
        pulse_start();
        step(); step(); step(); step();
        check_eq("underrun_set", 32'(underrun), 32'd1);
        check_eq("underrun_no_dv", 32'(core_data_valid), 32'd0);
        pulse_stop();
        wait_idle(20);
        check_eq("underrun_sticky", 32'(underrun), 32'd1);
        pulse_start();
        check_eq("underrun_cleared", 32'(underrun), 32'd0);
        pulse_stop();
        wait_idle(20);
        check_eq("underrun_not_in_drain", 32'(underrun), 32'd0);

        // start with stop in IDLE stays idle.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check_eq("start_stop_idle", 32'(busy), 32'd0);

        // Fill FIFO to full in IDLE.
        for (int i = 0; i < 16; i++) begin
            push(11'(1024 + i));
            if (i == 14) check_eq("ready_at_15", 32'(in_ready), 32'd1);
        end
        check_eq("full_not_ready", 32'(in_ready), 32'd0);
        pulse_start();
        step(); step(); step();
        check_eq("full_before_pop", 32'(in_ready), 32'd0);
        step();
        check_eq("ready_after_pop", 32'(in_ready), 32'd1);
        check_eq("fill_val0", 32'(core_ecg_value), 32'd0);
        for (int k = 0; k < 40; k++) step();
        check_eq("fill_dv11", 32'(core_data_valid), 32'd1);
        check_eq("fill_val10", 32'(core_ecg_value), 32'd10);
        check_eq("fill_scnt11", 32'(sample_count), 32'd11);
        step(); step();

        // Reset mid-run with five samples still queued.
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ce", 32'(core_ce), 32'd0);
        check_eq("mid_rst_dv", 32'(core_data_valid), 32'd0);
        check_eq("mid_rst_val", 32'(core_ecg_value), 32'd0);
        check_eq("mid_rst_scnt", 32'(sample_count), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
        pulse_start();
        step(); step(); step(); step();
        check_eq("flushed_underrun", 32'(underrun), 32'd1);
        check_eq("flushed_no_dv", 32'(core_data_valid), 32'd0);

        // Event capture, overflow, consume, and consume-with-replace.
        core_event(11'd280, 22'd370, 1'b0);
        check_eq("evt1_valid", 32'(evt_valid), 32'd1);
        check_eq("evt1_rr", 32'(evt_rr_period), 32'd280);
        check_eq("evt1_idx", 32'(evt_sample_num), 32'd370);
        check_eq("evt1_ovf", 32'(evt_overflow), 32'd0);
        core_event(11'd290, 22'd660, 1'b0);
        check_eq("evt2_rr_held", 32'(evt_rr_period), 32'd280);
        check_eq("evt2_idx_held", 32'(evt_sample_num), 32'd370);
        check_eq("evt2_ovf", 32'(evt_overflow), 32'd1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check_eq("evt_consumed", 32'(evt_valid), 32'd0);
        core_event(11'd300, 22'd700, 1'b0);
        core_event(11'd310, 22'd710, 1'b1);
        check_eq("evt_replace_valid", 32'(evt_valid), 32'd1);
        check_eq("evt_replace_rr", 32'(evt_rr_period), 32'd310);
        check_eq("evt_replace_idx", 32'(evt_sample_num), 32'd710);
        pulse_stop();
        wait_idle(20);
        check_eq("evt_held_idle", 32'(evt_valid), 32'd1);
        check_eq("evt_held_idle_rr", 32'(evt_rr_period), 32'd310);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check_eq("evt_consume_idle", 32'(evt_valid), 32'd0);
        core_event(11'd400, 22'd800, 1'b0);
        check_eq("evt_ignored_idle", 32'(evt_valid), 32'd0);

        // Stop in RUN with two samples queued.
        push(11'd1100); push(11'd900);
        pulse_start();
        pulse_stop();
        step(); step(); step();
        check_eq("drain2_dv0", 32'(core_data_valid), 32'd1);
        check_eq("drain2_val0", 32'(core_ecg_value), 32'd76);
        step(); step(); step(); step();
        check_eq("drain2_dv1", 32'(core_data_valid), 32'd1);
        check_eq("drain2_val1", 32'(core_ecg_value), 32'd1924);
        check_eq("drain2_scnt", 32'(sample_count), 32'd2);
        step(); step(); step();
        check_eq("drain2_busy", 32'(busy), 32'd1);
        step();
        check_eq("drain2_idle", 32'(busy), 32'd0);
        check_eq("drain2_ce", 32'(core_ce), 32'd0);
        check_eq("drain2_no_dv", 32'(core_data_valid), 32'd0);
        check_eq("drain2_no_underrun", 32'(underrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alg_stream_ctrl.md
Name: alg_stream_ctrl

Overview:
Sequencing controller in front of alg_core. It accepts raw offset-binary ECG samples over a valid/ready handshake and buffers them in a small FIFO. It converts each sample to signed two's complement and issues samples to alg_core at a fixed pacing interval, driving data_valid and ce. It also captures alg_core's RR-period update events into a held result register with a consumer handshake, and reports run status, sample count and sticky error flags.

Parameters:
DATA_WIDTH, 11, sample width (raw and signed)
CTR_WIDTH, 22, sample counter / R-peak index width
DATA_OFFSET, 1024, offset subtracted from raw samples
FIFO_DEPTH, 16, input buffer depth; power of 2, >=4
SAMPLE_DIV, 4, clocks per issued sample; >=2

Ports:
clk  in  1  system clock
nrst  in  1  synchronous active-low reset
start  in  1  one-cycle command: begin run
stop  in  1  one-cycle command: finish run after draining FIFO
in_data  in  DATA_WIDTH  raw offset-binary sample
in_valid  in  1  in_data valid
in_ready  out  1  controller can accept in_data
core_ce  out  1  alg_core clock enable
core_data_valid  out  1  one-cycle sample strobe to alg_core
core_ecg_value  out  DATA_WIDTH  signed sample to alg_core
core_rr_period  in  DATA_WIDTH  from alg_core
core_rr_period_updated  in  1  from alg_core, one-cycle pulse
core_r_peak_sample_num  in  CTR_WIDTH  from alg_core
evt_valid  out  1  result held
evt_rr_period  out  DATA_WIDTH  captured RR period
evt_sample_num  out  CTR_WIDTH  captured R-peak sample index
evt_ready  in  1  consumer accepts result
busy  out  1  state != IDLE
sample_count  out  CTR_WIDTH  samples issued this run
underrun  out  1  sticky: pacing tick in RUN with empty FIFO
evt_overflow  out  1  sticky: event lost while evt_valid held

Behaviour:
- Reset (nrst=0 at a clk edge): state IDLE, FIFO emptied, div_cnt=0. All outputs 0, except in_ready, which is 1 after reset because the FIFO is empty.
- FSM states are IDLE, RUN and DRAIN.
  - IDLE: start (with stop=0) moves to RUN. At the same edge it sets div_cnt=0 and clears sample_count, underrun and evt_overflow. stop alone is ignored. start and stop together keep the FSM in IDLE.
  - RUN: stop moves to DRAIN. start is ignored. If start and stop arrive together, stop wins.
  - DRAIN: move to IDLE at the first pacing tick where the FIFO is empty. No issue and no underrun occur at that tick. start and stop are ignored.
- core_ce=1 in RUN and DRAIN, 0 in IDLE.
- Input handshake: in_ready = FIFO not full, in every state, so the FIFO can be prefilled in IDLE. A push occurs on in_valid & in_ready.
- Pacing:
  - In RUN/DRAIN, div_cnt increments each edge and wraps at SAMPLE_DIV-1. The edge where div_cnt==SAMPLE_DIV-1 is a tick.
  - At a tick with the FIFO non-empty, pop one entry and register core_ecg_value = popped raw value - DATA_OFFSET (mod 2^DATA_WIDTH). Assert core_data_valid for exactly one cycle.
  - Result: the first strobe is visible after edge E+SAMPLE_DIV, where E is the edge that accepted start. Strobes are then at most one per SAMPLE_DIV cycles.
  - At a tick in RUN with the FIFO empty: no strobe, underrun<=1, and the counter keeps running.
- core_ecg_value holds its last value between strobes.
- sample_count increments per strobe and saturates at all-ones.
- Push and pop in the same edge are both allowed. Occupancy is unchanged, and a full FIFO frees its slot at the next edge.
- Event capture, active only in RUN/DRAIN:
  - On core_rr_period_updated with evt_valid=0, or with evt_valid=1 and evt_ready=1 in the same cycle, load evt_rr_period and evt_sample_num and set evt_valid=1 at the next edge.
  - On core_rr_period_updated with evt_valid=1 and evt_ready=0, drop the event, keep the held data and set evt_overflow<=1.
  - evt_ready with evt_valid=1 and no new event clears evt_valid.
- A held event survives the return to IDLE until consumed.
- Reset mid-run aborts immediately: FIFO contents and held event are discarded and all outputs take their reset values.

Decomposition:
- Package alg_pkg:
  - enum ctrl_state_t {IDLE, RUN, DRAIN};
  - localparams DEF_DATA_WIDTH=11, DEF_CTR_WIDTH=22, DEF_DATA_OFFSET=1024.
- Sub-module sync_fifo, parameters WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Synchronous active-low nrst; read is first-word-fall-through.
- Controller top: FSM, pacing counter, conversion, event register.

Test Plan:
- Prefill 3 samples {1024, 1500, 200} in IDLE, then start with SAMPLE_DIV=4 -> core_ecg_value 0, 476, -824 (0x4C8), strobes at edges E+4, E+8, E+12. sample_count=3, core_ce=1 from E+1.
- Run with FIFO empty at the first tick -> no strobe, underrun=1. underrun stays 1 until the next start, which clears it.
- Push 16 samples in IDLE -> in_ready=0 after the 16th push. In RUN, the first pop restores in_ready=1 the following cycle.
- Stop in RUN with 2 samples queued -> 2 more strobes, then IDLE at the next tick. busy=0 and core_ce=0 thereafter.
- Inject core_rr_period_updated (rr=280, idx=370) with evt_ready=0, then a second event (rr=290, idx=660) -> evt holds 280/370 and evt_overflow=1. Asserting evt_ready then clears evt_valid.
- Assert nrst=0 mid-RUN with 5 samples queued -> next cycle: state IDLE, FIFO empty, all flags 0, core_data_valid=0.
